// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART bus sequencer: state encoding, mode codes, timing defaults.
package uart_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RX_WAIT,
    ST_RX_STROBE,
    ST_RX_CAPT,
    ST_TX_SETUP,
    ST_TX_STROBE,
    ST_TX_WAIT_TBRE,
    ST_TX_WAIT_TSRE,
    ST_FINISH
  } state_e;

  localparam logic [1:0] MODE_RX   = 2'b00;
  localparam logic [1:0] MODE_TX   = 2'b01;
  localparam logic [1:0] MODE_ECHO = 2'b10;

  localparam int unsigned PULSE_DEFAULT   = 2;
  localparam int unsigned TIMEOUT_DEFAULT = 65535;

  function automatic logic [7:0] inc_byte(input logic [7:0] b);
    return b + 8'd1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous status line, reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/uart_bus_sequencer.sv
// Sequences UART read/write strobes on a shared bus: receive, send, or receive-then-echo (byte+1).
module uart_bus_sequencer
  import uart_pkg::*;
#(
  parameter int unsigned PULSE   = PULSE_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [7:0] tx_byte,
  input  logic       data_ready,
  input  logic       tbre,
  input  logic       tsre,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       rdn,
  output logic       wrn,
  output logic       ram_en,
  output logic       ram_oe,
  output logic       ram_we,
  output logic [7:0] rx_byte,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);

  state_e        state_q;
  logic [1:0]    mode_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    bus_out_q, rx_byte_q;
  logic          bus_oe_q, rdn_q, wrn_q, busy_q, done_q, err_q;
  logic          dr_s, tbre_s, tsre_s;

  sync2 u_sync_dr   (.clk(clk), .rst(rst), .d(data_ready), .q(dr_s));
  sync2 u_sync_tbre (.clk(clk), .rst(rst), .d(tbre),       .q(tbre_s));
  sync2 u_sync_tsre (.clk(clk), .rst(rst), .d(tsre),       .q(tsre_s));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= '0;
      cnt_q     <= '0;
      bus_out_q <= '0;
      rx_byte_q <= '0;
      bus_oe_q  <= 1'b0;
      rdn_q     <= 1'b1;
      wrn_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (start) begin
            busy_q <= 1'b1;
            mode_q <= mode;
            if (mode == MODE_RX || mode == MODE_ECHO) begin
              err_q   <= 1'b0;
              state_q <= ST_RX_WAIT;
            end else if (mode == MODE_TX) begin
              err_q     <= 1'b0;
              bus_out_q <= tx_byte;
              bus_oe_q  <= 1'b1;
              state_q   <= ST_TX_SETUP;
            end else begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= ST_FINISH;
            end
          end
        end
        ST_RX_WAIT: begin
          if (dr_s) begin
            rdn_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_RX_STROBE;
          end else if (cnt_q == TO_LAST) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_RX_STROBE: begin
          // Bus is sampled on the edge that ends the low pulse, so rdn is still 0 at capture.
          if (cnt_q == PULSE_LAST) begin
            rx_byte_q <= bus_in;
            rdn_q     <= 1'b1;
            cnt_q     <= '0;
            state_q   <= ST_RX_CAPT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_RX_CAPT: begin
          if (mode_q == MODE_ECHO) begin
            bus_out_q <= inc_byte(rx_byte_q);
            bus_oe_q  <= 1'b1;
            state_q   <= ST_TX_SETUP;
          end else begin
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end
        end
        ST_TX_SETUP: begin
          wrn_q   <= 1'b0;
          cnt_q   <= '0;
          state_q <= ST_TX_STROBE;
        end
        ST_TX_STROBE: begin
          // bus_oe stays high through the first wait cycle, giving one cycle of data hold after wrn rises.
          if (cnt_q == PULSE_LAST) begin
            wrn_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_TX_WAIT_TBRE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_TX_WAIT_TBRE, ST_TX_WAIT_TSRE: begin
          bus_oe_q <= 1'b0;
          if ((state_q == ST_TX_WAIT_TBRE) ? tbre_s : tsre_s) begin
            cnt_q   <= '0;
            if (state_q == ST_TX_WAIT_TSRE) begin
              done_q <= 1'b1;
            end
            state_q <= (state_q == ST_TX_WAIT_TBRE) ? ST_TX_WAIT_TSRE : ST_FINISH;
          end else if (cnt_q == TO_LAST) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_FINISH: begin
          rdn_q    <= 1'b1;
          wrn_q    <= 1'b1;
          bus_oe_q <= 1'b0;
          busy_q   <= 1'b0;
          cnt_q    <= '0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_out = bus_out_q;
  assign bus_oe  = bus_oe_q;
  assign rdn     = rdn_q;
  assign wrn     = wrn_q;
  assign rx_byte = rx_byte_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign ram_en  = 1'b1;
  assign ram_oe  = 1'b1;
  assign ram_we  = 1'b1;

endmodule

// File: tb/tb_uart_bus_sequencer.sv
// Scoreboard bench for uart_bus_sequencer: directed transfers, timeout, illegal mode, busy-start and reset abort.
module tb_uart_bus_sequencer;

  localparam int unsigned PULSE   = 2;
  localparam int unsigned TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] tx_byte = 8'h00;
  logic       data_ready = 1'b0, tbre = 1'b0, tsre = 1'b0;
  logic [7:0] bus_in = 8'h00;
  logic [7:0] bus_out, rx_byte;
  logic       bus_oe, rdn, wrn, ram_en, ram_oe, ram_we, busy, done, err;

  uart_bus_sequencer #(.PULSE(PULSE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .tx_byte(tx_byte),
    .data_ready(data_ready), .tbre(tbre), .tsre(tsre), .bus_in(bus_in),
    .bus_out(bus_out), .bus_oe(bus_oe), .rdn(rdn), .wrn(wrn),
    .ram_en(ram_en), .ram_oe(ram_oe), .ram_we(ram_we),
    .rx_byte(rx_byte), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rx;
    logic       err;
    logic       chk_rx;
  } exp_t;

  exp_t       doneq[$];
  logic [7:0] txq[$];
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic sel_sig(input int sel);
    case (sel)
      0: return rdn;
      1: return wrn;
      default: return busy;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic val, input int maxc, input string nm);
    int n = 0;
    while (sel_sig(sel) !== val && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {31'd0, sel_sig(sel)}, {31'd0, val});
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [7:0] tb);
    @(posedge clk); #1;
    mode = m; tx_byte = tb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Monitor: scoreboard for done pulses and write strobes, plus bus/strobe invariants.
  initial begin
    exp_t e;
    logic wrn_prev = 1'b1, rdn_prev = 1'b1;
    int   wlen = 0, rlen = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("invariants", {27'd0, (!rdn && bus_oe), (!rdn && !wrn), ram_en, ram_oe, ram_we},
            {27'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
        if (done) begin
          done_cnt++;
          if (doneq.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = doneq.pop_front();
            chk("done_err", {31'd0, err}, {31'd0, e.err});
            if (e.chk_rx) chk("done_rx_byte", {24'd0, rx_byte}, {24'd0, e.rx});
          end
        end
        if (!wrn) begin
          wlen++;
          if (txq.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
          else chk("write_bus", {23'd0, bus_oe, bus_out}, {23'd0, 1'b1, txq[0]});
        end else if (!wrn_prev) begin
          chk("wrn_pulse_len", wlen, PULSE);
          if (txq.size() != 0) void'(txq.pop_front());
          wlen = 0;
        end
        if (!rdn) rlen++;
        else if (!rdn_prev) begin
          chk("rdn_pulse_len", rlen, PULSE);
          rlen = 0;
        end
      end else begin
        if (!wrn_prev && txq.size() != 0) void'(txq.pop_front());
        wlen = 0;
        rlen = 0;
      end
      wrn_prev = wrn;
      rdn_prev = rdn;
    end
  end

  initial begin
    int n;
    int dc0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_strobes", {30'd0, rdn, wrn}, 32'd3);
    chk("rst_bus", {23'd0, bus_oe, bus_out}, 32'd0);
    chk("rst_status", {21'd0, rx_byte, busy, done, err}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Receive 0x5A
    bus_in = 8'h5A;
    doneq.push_back('{rx: 8'h5A, err: 1'b0, chk_rx: 1'b1});
    pulse_start(2'b00, 8'h00);
    @(negedge clk);
    chk("rx_busy", {31'd0, busy}, 32'd1);
    chk("rx_wait_rdn", {30'd0, rdn, bus_oe}, 32'd2);
    repeat (3) @(posedge clk);
    #1 data_ready = 1'b1;
    wait_for(0, 1'b0, 20, "rx_rdn_fall");
    wait_for(0, 1'b1, 20, "rx_rdn_rise");
    data_ready = 1'b0;
    wait_for(2, 1'b0, 20, "rx_idle");
    chk("rx_byte_final", {24'd0, rx_byte}, 32'h5A);

    // Send 0xC3; tbre 10 cycles, tsre 20 cycles after wrn rises
    txq.push_back(8'hC3);
    doneq.push_back('{rx: 8'h00, err: 1'b0, chk_rx: 1'b0});
    pulse_start(2'b01, 8'hC3);
    wait_for(1, 1'b0, 20, "tx_wrn_fall");
    wait_for(1, 1'b1, 20, "tx_wrn_rise");
    repeat (10) @(posedge clk);
    #1 tbre = 1'b1;
    repeat (10) @(posedge clk);
    chk("tx_busy_before_tsre", {30'd0, busy, done}, 32'd2);
    #1 tsre = 1'b1;
    wait_for(2, 1'b0, 40, "tx_idle");
    chk("tx_bus_released", {31'd0, bus_oe}, 32'd0);
    tbre = 1'b0; tsre = 1'b0;

    // Echo with wrap: 0xFF received, 0x00 sent, one done
    dc0 = done_cnt;
    bus_in = 8'hFF;
    txq.push_back(8'h00);
    doneq.push_back('{rx: 8'hFF, err: 1'b0, chk_rx: 1'b1});
    pulse_start(2'b10, 8'h00);
    #1 data_ready = 1'b1;
    wait_for(0, 1'b0, 20, "echo_rdn_fall");
    wait_for(0, 1'b1, 20, "echo_rdn_rise");
    data_ready = 1'b0;
    wait_for(1, 1'b0, 20, "echo_wrn_fall");
    wait_for(1, 1'b1, 20, "echo_wrn_rise");
    tbre = 1'b1; tsre = 1'b1;
    wait_for(2, 1'b0, 40, "echo_idle");
    chk("echo_done_count", done_cnt - dc0, 32'd1);
    chk("echo_rx_byte", {24'd0, rx_byte}, 32'hFF);
    tbre = 1'b0; tsre = 1'b0;

    // Timeout in RX_WAIT, then a valid start clears err
    doneq.push_back('{rx: 8'h00, err: 1'b1, chk_rx: 1'b0});
    pulse_start(2'b00, 8'h00);
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    chk("timeout_window", {31'd0, (n >= 99 && n <= 103)}, 32'd1);
    chk("timeout_state", {30'd0, rdn, err}, 32'd3);
    wait_for(2, 1'b0, 5, "timeout_idle");
    chk("timeout_err_held", {31'd0, err}, 32'd1);
    tbre = 1'b1; tsre = 1'b1;
    txq.push_back(8'h11);
    doneq.push_back('{rx: 8'h00, err: 1'b0, chk_rx: 1'b0});
    pulse_start(2'b01, 8'h11);
    @(negedge clk);
    chk("err_cleared", {31'd0, err}, 32'd0);
    wait_for(2, 1'b0, 40, "clear_idle");
    tbre = 1'b0; tsre = 1'b0;

    // Start while busy is ignored
    txq.push_back(8'h3C);
    doneq.push_back('{rx: 8'h00, err: 1'b0, chk_rx: 1'b0});
    pulse_start(2'b01, 8'h3C);
    wait_for(1, 1'b0, 20, "busy_wrn_fall");
    wait_for(1, 1'b1, 20, "busy_wrn_rise");
    pulse_start(2'b00, 8'h00);
    repeat (3) @(posedge clk);
    #1 tbre = 1'b1; tsre = 1'b1;
    wait_for(2, 1'b0, 300, "busy_idle");
    repeat (120) @(negedge clk);
    chk("busy_start_ignored", {31'd0, busy}, 32'd0);
    tbre = 1'b0; tsre = 1'b0;

    // Illegal mode
    doneq.push_back('{rx: 8'h00, err: 1'b1, chk_rx: 1'b0});
    pulse_start(2'b11, 8'h00);
    wait_for(2, 1'b0, 10, "illegal_idle");
    chk("illegal_err", {31'd0, err}, 32'd1);

    // Reset during TX_STROBE aborts asynchronously
    txq.push_back(8'h77);
    pulse_start(2'b01, 8'h77);
    wait_for(1, 1'b0, 20, "abort_wrn_fall");
    #2 rst = 1'b1;
    #1;
    chk("abort_async", {29'd0, wrn, bus_oe, busy}, 32'd4);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_quiet", {29'd0, busy, done, err}, 32'd0);
    chk("scoreboard_drained", doneq.size() + txq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_bus_sequencer.md
UART_BUS_SEQUENCER -- requirements
Module: uart_bus_sequencer

Interface
REQ-001 SHALL have parameter PULSE, default 2: rdn/wrn low-pulse width in clk cycles (1..15).
REQ-002 SHALL have parameter TIMEOUT, default 65535: maximum cycles spent in any wait state.
REQ-003 SHALL have clk  in  1  single system clock, rising edge; rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have start  in  1  one-cycle request pulse, sampled only in IDLE.
REQ-005 SHALL have mode  in  2  00=receive, 01=send, 10=echo-plus-one, 11=illegal.
REQ-006 SHALL have tx_byte  in  8  byte to send in mode 01, captured at start.
REQ-007 SHALL have data_ready, tbre, tsre  in  1 each  UART status lines, asynchronous to clk.
REQ-008 SHALL have bus_in  in  8  shared data bus read value.
REQ-009 SHALL have bus_out  out  8 and bus_oe  out  1  shared-bus drive value and drive enable.
REQ-010 SHALL have rdn, wrn  out  1 each  UART read and write strobes, active-low.
REQ-011 SHALL have ram_en, ram_oe, ram_we  out  1 each  RAM controls, active-low, held 1.
REQ-012 SHALL have rx_byte  out  8, busy  out  1, done  out  1, err  out  1  result and status.

Function
REQ-013 SHALL pass data_ready, tbre and tsre through 2-flop synchronizers; all decisions use synchronized values (2-cycle latency).
REQ-014 SHALL hold ram_en=ram_oe=ram_we=1 at all times, so the RAM never contends for the bus.
REQ-015 SHALL implement states IDLE, RX_WAIT, RX_STROBE, RX_CAPT, TX_SETUP, TX_STROBE, TX_WAIT_TBRE, TX_WAIT_TSRE, FINISH.
REQ-016 SHALL, in IDLE with start=1: go to RX_WAIT for modes 00 and 10, or TX_SETUP for mode 01 (latching tx_byte); go to FINISH with err=1 for mode 11.
REQ-017 SHALL in RX_WAIT hold rdn=1 and bus_oe=0 until synchronized data_ready=1, then enter RX_STROBE.
REQ-018 SHALL in RX_STROBE drive rdn=0 for exactly PULSE cycles, then enter RX_CAPT.
REQ-019 SHALL in RX_CAPT register bus_in into rx_byte while rdn is still 0, then raise rdn=1 the next cycle.
REQ-020 SHALL leave RX_CAPT to FINISH in mode 00, or to TX_SETUP in mode 10 with tx data = rx_byte+1 modulo 256 (0xFF -> 0x00).
REQ-021 SHALL in TX_SETUP assert bus_oe=1 with bus_out=tx data for 1 cycle before wrn falls.
REQ-022 SHALL in TX_STROBE drive wrn=0 for PULSE cycles with bus_oe=1, then raise wrn=1 and drop bus_oe one cycle later.
REQ-023 SHALL wait in TX_WAIT_TBRE for tbre=1, then in TX_WAIT_TSRE for tsre=1, then enter FINISH.
REQ-024 SHALL count cycles in RX_WAIT, TX_WAIT_TBRE and TX_WAIT_TSRE; on reaching TIMEOUT it SHALL enter FINISH with err=1, rdn=wrn=1 and bus_oe=0.
REQ-025 SHALL in FINISH pulse done=1 for one cycle and return to IDLE; err holds until the next accepted start.
REQ-026 SHALL keep busy=1 in every state except IDLE; start while busy is ignored.
REQ-027 SHALL never assert rdn=0 and bus_oe=1 in the same cycle, nor rdn=0 and wrn=0 together.

Reset
REQ-028 SHALL on rst=1 immediately set state=IDLE, rdn=1, wrn=1, bus_oe=0, bus_out=0, rx_byte=0, busy=0, done=0, err=0, counters=0 and synchronizers=0.
REQ-029 SHALL treat a reset mid-transfer as an abort: strobes rise and the bus is released asynchronously, with no done pulse.

Structure
REQ-030 SHALL take the state encoding, the mode codes (MODE_RX, MODE_TX, MODE_ECHO) and the PULSE/TIMEOUT defaults from the shared package uart_pkg.
REQ-031 SHALL place the 2-flop synchronizer in the single sub-module sync2, instantiated three times; all other logic is flat.

Verification
REQ-032 Receive: mode=00, start; UART model raises data_ready and drives 0x5A -> rdn low for 2 cycles, rx_byte=0x5A, done pulse, err=0.
REQ-033 Send: mode=01, tx_byte=0xC3, start; tbre/tsre rise 10 and 20 cycles after wrn rises -> bus_out=0xC3 throughout wrn low, done after tsre, bus_oe=0 afterwards.
REQ-034 Echo wrap: mode=10, received byte 0xFF -> rx_byte=0xFF and transmitted byte 0x00; one done pulse in total.
REQ-035 Timeout: TIMEOUT=100, mode=00, data_ready held 0 -> done and err at cycle ~100, rdn=1, busy=0; the next valid start clears err.
REQ-036 Reset and abort: assert rst during TX_STROBE -> wrn=1 and bus_oe=0 without waiting for a clk edge, no done; start during busy and mode=11 -> ignored and err=1 respectively; ram_en/oe/we stay 1 throughout.
